// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, ROM request issue and 2-entry tagged instruction FIFO
module instr_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    input  logic        instr_ready
);

    logic [31:0] pc;
    logic [31:0] req_pc_q;
    logic        req_q;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_addr  [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] jmp_target;

    assign jmp_target  = jmp_addr & 32'hFFFF_FFFC;
    assign instr_valid = (count != 2'd0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_addr  = fifo_addr[rd_ptr];
    assign mem_addr    = pc;

    assign pop  = instr_valid & instr_ready & ~jmp_valid;
    assign push = req_q & ~jmp_valid;

    // Words already buffered plus the one in flight; pop implies count>=1, so no underflow.
    assign occupancy = {1'b0, count} + {2'b00, req_q} - {2'b00, pop};
    assign issue     = ~jmp_valid & (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc            <= BOOT_ADDR;
            req_q         <= 1'b0;
            req_pc_q      <= 32'h0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_instr[0] <= 32'h0;
            fifo_instr[1] <= 32'h0;
            fifo_addr[0]  <= 32'h0;
            fifo_addr[1]  <= 32'h0;
        end else if (jmp_valid) begin
            pc     <= jmp_target;
            req_q  <= 1'b0;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (issue) begin
                pc       <= pc + 32'd4;
                req_q    <= 1'b1;
                req_pc_q <= pc;
            end else begin
                req_q <= 1'b0;
            end

            if (push) begin
                fifo_instr[wr_ptr] <= mem_rdata;
                fifo_addr[wr_ptr]  <= req_pc_q;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jmp_valid;
    logic [31:0] jmp_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready)
    );

    // 16-word ROM: word i holds i, except the last word which is all ones.
    function automatic logic [31:0] rom_word(input logic [3:0] idx);
        return (idx == 4'd15) ? 32'hFFFF_FFFF : {28'h0, idx};
    endfunction

    always_ff @(posedge clk) mem_rdata <= rom_word(mem_addr[5:2]);

    task automatic next;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, {31'h0, instr_valid}, 32'd1);
        chk({tag, "_addr"}, instr_addr, a);
        chk({tag, "_instr"}, instr, d);
    endtask

    task automatic do_reset;
        rstn        = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = 32'h0;
        instr_ready = 1'b1;
        next;
        next;
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rstn = 1'b1;
        cyc  = 0;
    endtask

    task automatic jump_case(input logic [31:0] tgt, input logic [31:0] exp_a, input logic [31:0] exp_d);
        do_reset;
        for (int i = 0; i < 6; i++) next;
        chk_head("jmp_pre", 32'h10, 32'd4);
        jmp_valid = 1'b1;
        jmp_addr  = tgt;
        next;
        jmp_valid = 1'b0;
        chk("jmp_c7_valid", {31'h0, instr_valid}, 32'd0);
        chk("jmp_c7_mem_addr", mem_addr, exp_a);
        next;
        chk("jmp_c8_valid", {31'h0, instr_valid}, 32'd0);
        next;
        chk_head("jmp_c9", exp_a, exp_d);
        next;
        chk_head("jmp_c10", exp_a + 32'd4, exp_d + 32'd1);
    endtask

    initial begin
        // Boot stream with no bubbles
        do_reset;
        chk("boot_c0_mem_addr", mem_addr, 32'h0);
        chk("boot_c0_valid", {31'h0, instr_valid}, 32'd0);
        next;
        chk("boot_c1_valid", {31'h0, instr_valid}, 32'd0);
        chk("boot_c1_mem_addr", mem_addr, 32'h4);
        next;
        for (int k = 0; k < 16; k++) begin
            chk_head("boot", 32'(4 * k), rom_word(4'(k)));
            next;
        end

        // Backpressure from cycle 3 to 10
        do_reset;
        next;
        next;
        next;
        for (int c = 3; c <= 10; c++) begin
            chk_head("bp_hold", 32'h4, 32'd1);
            chk("bp_mem_addr", mem_addr, 32'hC);
            if (c == 3) instr_ready = 1'b0;
            next;
        end
        instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk_head("bp_resume", 32'(4 * k), 32'(k));
            next;
        end

        // Aligned and misaligned jumps in cycle 6
        jump_case(32'h20, 32'h20, 32'h8);
        jump_case(32'h2B, 32'h28, 32'hA);

        // Jump into a full FIFO with a handshake, then back-to-back jumps
        do_reset;
        next;
        next;
        instr_ready = 1'b0;
        next;
        chk_head("full_head", 32'h0, 32'h0);
        instr_ready = 1'b1;
        jmp_valid   = 1'b1;
        jmp_addr    = 32'h10;
        next;
        chk("b2b_c4_valid", {31'h0, instr_valid}, 32'd0);
        chk("b2b_c4_mem_addr", mem_addr, 32'h10);
        jmp_addr = 32'h30;
        next;
        jmp_valid = 1'b0;
        chk("b2b_c5_valid", {31'h0, instr_valid}, 32'd0);
        chk("b2b_c5_mem_addr", mem_addr, 32'h30);
        next;
        chk("b2b_c6_valid", {31'h0, instr_valid}, 32'd0);
        next;
        chk_head("b2b_c7", 32'h30, 32'hC);
        next;
        chk_head("b2b_c8", 32'h34, 32'hD);

        // Reset mid-stream
        do_reset;
        for (int i = 0; i < 5; i++) next;
        chk_head("mid_pre", 32'hC, 32'd3);
        rstn = 1'b0;
        next;
        chk("mid_valid", {31'h0, instr_valid}, 32'd0);
        chk("mid_mem_addr", mem_addr, 32'h0);
        rstn = 1'b1;
        next;
        chk("mid_c1_valid", {31'h0, instr_valid}, 32'd0);
        next;
        chk_head("mid_restart", 32'h0, 32'h0);

        // PC wrap at the top of the address space
        do_reset;
        next;
        next;
        next;
        jmp_valid = 1'b1;
        jmp_addr  = 32'hFFFF_FFFF;
        next;
        jmp_valid = 1'b0;
        chk("wrap_mem_addr0", mem_addr, 32'hFFFF_FFFC);
        next;
        chk("wrap_mem_addr1", mem_addr, 32'h0);
        next;
        chk_head("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FFFF);
        next;
        chk_head("wrap_zero", 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage that drives the address port of the single-port instruction ROM/BRAM and consumes its 1-cycle-latency data output.
- Keeps the program counter and issues one word read per cycle.
- Tags each returned word with its address and buffers it in a 2-entry FIFO.
- Presents instructions to the decode stage over a valid/ready handshake; a jump input redirects the PC and flushes in-flight and buffered words.

Parameters:
- BOOT_ADDR, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- jmp_valid  in  1  redirect request this cycle
- jmp_addr  in  32  redirect target; bits [1:0] ignored, treated as 0
- mem_addr  out  32  byte address to the ROM addr port; combinational from PC
- mem_rdata  in  32  ROM dout; carries the word for the mem_addr presented one cycle earlier
- instr_valid  out  1  FIFO head valid
- instr  out  32  FIFO head instruction word
- instr_addr  out  32  FIFO head address
- instr_ready  in  1  decode accepts head this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset values (at the edge where rstn=0):
  - pc=BOOT_ADDR, req_q=0, req_pc_q=0.
  - FIFO count=0, read and write pointers=0.
  - Outputs: instr_valid=0, instr=0, instr_addr=0, mem_addr=BOOT_ADDR.
- ROM write enable is tied low at instantiation. The ROM registers dout every cycle, so valid data exists only when req_q=1.
- pop = instr_valid & instr_ready & ~jmp_valid.
- Issue condition: issue = ~jmp_valid & ((count + req_q - pop) < 2). Evaluate this in 3-bit arithmetic with no underflow.
- On issue:
  - mem_addr = pc.
  - Next edge: pc <= pc+4, wrapping at 2^32; req_q <= 1; req_pc_q <= pc.
- No issue: pc holds, req_q <= 0, mem_addr still equals pc (the returned data is ignored).
- Response: if req_q=1 and ~jmp_valid, push {req_pc_q, mem_rdata} at the next edge.
  - The issue rule guarantees the push never overflows; overflow is an assertion failure.
- FIFO:
  - 2 entries, pointer-based, circular.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - The head is visible the cycle after the push (registered storage).
- Outputs: instr_valid = (count != 0). instr and instr_addr are the head entry; they are don't-care when instr_valid=0 and hold stable while instr_valid=1 and instr_ready=0.
- Jump (jmp_valid=1 in cycle N):
  - At the N edge: pc <= {jmp_addr[31:2],2'b00}, count <= 0, pointers <= 0, req_q <= 0.
  - The response arriving in N+1 for a pre-jump issue is discarded.
  - Any handshake in cycle N is dropped; jump has priority.
  - The target is issued in N+1, data arrives in N+2, and instr_valid=1 with instr_addr=target in N+3.
  - Back-to-back jumps: the last one wins.
- Startup latency: for the first cycle with rstn=1 (cycle 0), BOOT_ADDR is issued in cycle 0, data arrives in cycle 1, and instr_valid=1 in cycle 2.
- Throughput: steady state is 1 instruction per cycle with instr_ready held high.
- Reset mid-operation (rstn=0 at any cycle): all state returns to reset values at that edge; in-flight data is lost.

Test Plan:
- Boot stream, ROM word i = i, BOOT_ADDR=0, instr_ready=1:
  - instr_valid rises in cycle 2.
  - Consecutive accepted pairs (addr,instr): (0,0),(4,1),(8,2)...(0x3C,0xFFFFFFFF), with no bubbles.
- Backpressure: instr_ready=0 from cycle 3 to cycle 10:
  - count saturates at 2 and issues stop.
  - The head stays stable.
  - On release, the stream resumes with no skipped or duplicated addresses.
- Jump: jmp_valid=1, jmp_addr=0x20 in cycle 6:
  - The next accepted instruction is (0x20,8) in cycle 9.
  - No pre-jump word is delivered after cycle 6.
- Misaligned jump: jmp_addr=0x2B -> first delivered pair is (0x28,0xA).
- Jump with a simultaneous handshake and a full FIFO:
  - The handshake is dropped and the FIFO is flushed.
  - Back-to-back jumps to 0x10 then 0x30 deliver only (0x30,0xC).
- Reset mid-stream: rstn=0 for 1 cycle during streaming:
  - instr_valid=0 the following cycle.
  - The stream restarts with (0,0) 2 cycles after rstn=1.
